rvga_ddr_arbiter: RTL

- Shares the single word-wide DDR port between the core's instruction-fetch port (read-only) and data port (read/write).
- One transaction in flight at a time; round-robin on contention.
- Registers all DDR-side request signals and guarantees the idle gap the DDR slave needs between transactions.
- Watchdog aborts a transaction that never receives ddr_resp.

---
 rtl/rvga_ddr_arbiter_pkg.sv | 22 ++
 rtl/rvga_rr_pick2.sv | 23 ++
 rtl/rvga_ddr_arbiter.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/rvga_ddr_arbiter_pkg.sv
// Shared types and defaults for the DDR port arbiter that sits between
// the core's fetch/data ports and the single DDR slave.
package rvga_ddr_arbiter_pkg;

  typedef logic [31:0] rvga_word;

  typedef enum logic {
    GRANT_INST = 1'b0,
    GRANT_DATA = 1'b1
  } rvga_ddr_grant_t;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_GAP  = 2'd2
  } rvga_arb_state_t;

  // Watchdog default in cycles; the counter width must hold DDR_TIMEOUT-1.
  localparam int DDR_TIMEOUT = 64;
  localparam int DDR_CNT_W   = 8;

endpackage

// File: rtl/rvga_rr_pick2.sv
// Two-way round-robin chooser: with both requests active, the requester
// that did not win last time gets the grant.
module rvga_rr_pick2
  import rvga_ddr_arbiter_pkg::*;
(
  input  logic [1:0]      i_req,
  input  rvga_ddr_grant_t i_last,
  output logic            o_valid,
  output rvga_ddr_grant_t o_grant
);

  // i_req[0] is the fetch port, i_req[1] the data port.
  always_comb begin
    o_valid = |i_req;
    o_grant = GRANT_INST;
    if (i_req == 2'b11) begin
      o_grant = (i_last == GRANT_INST) ? GRANT_DATA : GRANT_INST;
    end else if (i_req[1]) begin
      o_grant = GRANT_DATA;
    end
  end

endmodule

// File: rtl/rvga_ddr_arbiter.sv
// Shares the word-wide DDR port between instruction fetch and data access,
// one registered transaction at a time, with an idle gap and a watchdog.
module rvga_ddr_arbiter
  import rvga_ddr_arbiter_pkg::*;
#(
  parameter int TIMEOUT = DDR_TIMEOUT,
  parameter int CNT_W   = DDR_CNT_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_addr,
  input  logic        i_read,
  output logic [31:0] i_rdata,
  output logic        i_resp,
  input  logic [31:0] d_addr,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_resp,
  output logic [31:0] ddr_addr,
  output logic        ddr_read,
  output logic        ddr_write,
  output logic [31:0] ddr_wdata,
  input  logic [31:0] ddr_rdata,
  input  logic        ddr_resp,
  output logic        err
);

  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  rvga_arb_state_t r_state, w_state;
  rvga_ddr_grant_t r_last, w_last;
  rvga_ddr_grant_t r_owner, w_owner;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic [31:0] r_ddr_addr, w_ddr_addr;
  logic [31:0] r_ddr_wdata, w_ddr_wdata;
  logic r_ddr_read, w_ddr_read;
  logic r_ddr_write, w_ddr_write;
  logic [31:0] r_i_rdata, w_i_rdata;
  logic [31:0] r_d_rdata, w_d_rdata;
  logic r_i_resp, w_i_resp;
  logic r_d_resp, w_d_resp;
  logic r_err, w_err;

  logic w_pick_valid;
  rvga_ddr_grant_t w_pick;
  logic w_timeout;
  logic w_finish;

  rvga_rr_pick2 u_pick (
    .i_req   ({d_read | d_write, i_read}),
    .i_last  (r_last),
    .o_valid (w_pick_valid),
    .o_grant (w_pick)
  );

  assign w_timeout = (TIMEOUT > 0) && (r_cnt == CNT_LAST);

  always_comb begin
    w_state     = r_state;
    w_last      = r_last;
    w_owner     = r_owner;
    w_cnt       = r_cnt;
    w_ddr_addr  = r_ddr_addr;
    w_ddr_wdata = r_ddr_wdata;
    w_ddr_read  = r_ddr_read;
    w_ddr_write = r_ddr_write;
    w_i_rdata   = r_i_rdata;
    w_d_rdata   = r_d_rdata;
    w_i_resp    = 1'b0;
    w_d_resp    = 1'b0;
    w_err       = 1'b0;
    w_finish    = 1'b0;

    case (r_state)
      ARB_IDLE: begin
        if (w_pick_valid) begin
          w_state = ARB_BUSY;
          w_last  = w_pick;
          w_owner = w_pick;
          w_cnt   = '0;
          if (w_pick == GRANT_INST) begin
            w_ddr_addr  = i_addr;
            w_ddr_wdata = '0;
            w_ddr_read  = 1'b1;
            w_ddr_write = 1'b0;
          end else begin
            // A simultaneous read and write from the data port is a write.
            w_ddr_addr  = d_addr;
            w_ddr_wdata = d_wdata;
            w_ddr_read  = ~d_write;
            w_ddr_write = d_write;
          end
        end
      end

      ARB_BUSY: begin
        if (r_cnt != CNT_MAX) begin
          w_cnt = r_cnt + CNT_W'(1);
        end
        if (ddr_resp) begin
          w_finish = 1'b1;
          if (!r_ddr_write) begin
            if (r_owner == GRANT_INST) w_i_rdata = ddr_rdata;
            else                       w_d_rdata = ddr_rdata;
          end
        end else if (w_timeout) begin
          w_finish = 1'b1;
          w_err    = 1'b1;
          if (r_owner == GRANT_INST) w_i_rdata = '0;
          else                       w_d_rdata = '0;
        end
        if (w_finish) begin
          w_state     = ARB_GAP;
          w_ddr_read  = 1'b0;
          w_ddr_write = 1'b0;
          w_i_resp    = (r_owner == GRANT_INST);
          w_d_resp    = (r_owner == GRANT_DATA);
        end
      end

      ARB_GAP: begin
        w_state     = ARB_IDLE;
        w_ddr_read  = 1'b0;
        w_ddr_write = 1'b0;
      end

      default: begin
        w_state = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ARB_IDLE;
      r_last      <= GRANT_DATA;
      r_owner     <= GRANT_INST;
      r_cnt       <= '0;
      r_ddr_addr  <= '0;
      r_ddr_wdata <= '0;
      r_ddr_read  <= 1'b0;
      r_ddr_write <= 1'b0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
      r_i_resp    <= 1'b0;
      r_d_resp    <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_last      <= w_last;
      r_owner     <= w_owner;
      r_cnt       <= w_cnt;
      r_ddr_addr  <= w_ddr_addr;
      r_ddr_wdata <= w_ddr_wdata;
      r_ddr_read  <= w_ddr_read;
      r_ddr_write <= w_ddr_write;
      r_i_rdata   <= w_i_rdata;
      r_d_rdata   <= w_d_rdata;
      r_i_resp    <= w_i_resp;
      r_d_resp    <= w_d_resp;
      r_err       <= w_err;
    end
  end

  assign ddr_addr  = r_ddr_addr;
  assign ddr_wdata = r_ddr_wdata;
  assign ddr_read  = r_ddr_read;
  assign ddr_write = r_ddr_write;
  assign i_rdata   = r_i_rdata;
  assign d_rdata   = r_d_rdata;
  assign i_resp    = r_i_resp;
  assign d_resp    = r_d_resp;
  assign err       = r_err;

endmodule
